// File: rtl/idli_tb_trace_m.sv
// idli_tb_trace_m -- per-instruction retire trace for the bench.
//
// Collects side effects of the instruction in EX during phase 0 of the
// sync counter (register writes, predicate write, output-pin writes, PC).
// On retire (done strobe in phase 3), it pushes one record into a small FIFO
// that the bench drains with a valid/ready handshake.
//
// Ports:
//   i_tb_gck, i_tb_rst_n    clock, async active-low reset
//   i_tb_ctr                phase counter 0..3
//   i_tb_enc_new, i_tb_pc   PC capture
//   i_tb_reg_wr/_idx        register scoreboard (index 0 ignored)
//   i_tb_pred_wr, i_tb_skip predicate flag (= !skip, last write wins)
//   i_tb_pin_wr/_idx        pin scoreboard
//   i_tb_done               retire strobe (only honoured in phase 3)
//   i_tb_flush              empties FIFO, clears ovf/drops
//   o_tb_trc_*, i_tb_trc_rdy head record + handshake
//   o_tb_cnt, o_tb_afull    occupancy status
//   o_tb_ovf, o_tb_drops    sticky overflow, saturating drop count
module idli_tb_trace_m #(
  parameter int DEPTH    = 8,
  parameter int NUM_REGS = 16,
  parameter int PIN_W    = 4,
  parameter int DATA_W   = 16
) (
  input  logic                       i_tb_gck,
  input  logic                       i_tb_rst_n,
  input  logic [1:0]                 i_tb_ctr,
  input  logic                       i_tb_enc_new,
  input  logic [DATA_W-1:0]          i_tb_pc,
  input  logic                       i_tb_reg_wr,
  input  logic [$clog2(NUM_REGS)-1:0] i_tb_reg_idx,
  input  logic                       i_tb_pred_wr,
  input  logic                       i_tb_skip,
  input  logic                       i_tb_pin_wr,
  input  logic [$clog2(PIN_W)-1:0]   i_tb_pin_idx,
  input  logic                       i_tb_done,
  input  logic                       i_tb_flush,
  output logic                       o_tb_trc_vld,
  input  logic                       i_tb_trc_rdy,
  output logic [DATA_W-1:0]          o_tb_trc_pc,
  output logic [NUM_REGS-1:0]        o_tb_trc_reg_sb,
  output logic                       o_tb_trc_pred_sb,
  output logic [PIN_W-1:0]           o_tb_trc_pins_sb,
  output logic [7:0]                 o_tb_trc_seq,
  output logic [$clog2(DEPTH+1)-1:0] o_tb_cnt,
  output logic                       o_tb_afull,
  output logic                       o_tb_ovf,
  output logic [7:0]                 o_tb_drops
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [DATA_W-1:0]   pc;
    logic [NUM_REGS-1:0] reg_sb;
    logic                pred_sb;
    logic [PIN_W-1:0]    pins_sb;
    logic [7:0]          seq;
  } trc_rec_t;

  // The accumulator is laid out as a full record; its seq field is the
  // running retire counter, so a push writes it verbatim.
  trc_rec_t         acc;
  trc_rec_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             retire, full, pop, wr_en;

  assign retire = i_tb_done && (i_tb_ctr == 2'd3);
  assign full   = (cnt == CNT_W'(DEPTH));
  assign pop    = (cnt != '0) && i_tb_trc_rdy && !i_tb_flush;
  // Pop frees the slot on the same edge, so a full FIFO still accepts.
  assign wr_en  = retire && !i_tb_flush && (!full || pop);

  // Accumulate and retire live in different phases, so they never collide.
  always_ff @(posedge i_tb_gck or negedge i_tb_rst_n) begin
    if (!i_tb_rst_n) begin
      acc <= '0;
    end else begin
      if (retire) begin
        acc.reg_sb  <= '0;
        acc.pred_sb <= 1'b0;
        acc.pins_sb <= '0;
        acc.seq     <= acc.seq + 8'd1;
      end
      if (i_tb_ctr == 2'd0) begin
        if (i_tb_enc_new)                         acc.pc                  <= i_tb_pc;
        if (i_tb_reg_wr && (i_tb_reg_idx != '0))  acc.reg_sb[i_tb_reg_idx] <= 1'b1;
        if (i_tb_pred_wr)                         acc.pred_sb             <= !i_tb_skip;
        if (i_tb_pin_wr)                          acc.pins_sb[i_tb_pin_idx] <= 1'b1;
      end
    end
  end

  // Storage carries no reset; head contents are don't-care while vld=0.
  always_ff @(posedge i_tb_gck) begin
    if (wr_en) mem[wr_ptr] <= acc;
  end

  always_ff @(posedge i_tb_gck or negedge i_tb_rst_n) begin
    if (!i_tb_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      o_tb_ovf   <= 1'b0;
      o_tb_drops <= '0;
    end else if (i_tb_flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      o_tb_ovf   <= 1'b0;
      o_tb_drops <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en && !pop)      cnt <= cnt + CNT_W'(1);
      else if (!wr_en && pop) cnt <= cnt - CNT_W'(1);
      if (retire && full && !pop) begin
        o_tb_ovf <= 1'b1;
        if (o_tb_drops != 8'hFF) o_tb_drops <= o_tb_drops + 8'd1;
      end
    end
  end

  assign o_tb_cnt         = cnt;
  assign o_tb_trc_vld     = (cnt != '0);
  assign o_tb_afull       = (cnt >= CNT_W'(DEPTH-1));
  assign o_tb_trc_pc      = mem[rd_ptr].pc;
  assign o_tb_trc_reg_sb  = mem[rd_ptr].reg_sb;
  assign o_tb_trc_pred_sb = mem[rd_ptr].pred_sb;
  assign o_tb_trc_pins_sb = mem[rd_ptr].pins_sb;
  assign o_tb_trc_seq     = mem[rd_ptr].seq;

endmodule

// File: tb/tb_idli_tb_trace_m.sv
module tb_idli_tb_trace_m;
  localparam int DEPTH = 8, NUM_REGS = 16, PIN_W = 4, DATA_W = 16;
  localparam int RIW = $clog2(NUM_REGS), PIW = $clog2(PIN_W), CW = $clog2(DEPTH+1);

  logic              clk = 0, rst_n = 0;
  logic [1:0]        ctr = 0;
  logic              enc_new = 0, reg_wr = 0, pred_wr = 0, skip = 0, pin_wr = 0;
  logic              done = 0, flush = 0, rdy = 0;
  logic [DATA_W-1:0] pc = 0;
  logic [RIW-1:0]    reg_idx = 0;
  logic [PIW-1:0]    pin_idx = 0;
  logic              trc_vld, trc_pred, afull, ovf;
  logic [DATA_W-1:0] trc_pc;
  logic [NUM_REGS-1:0] trc_reg;
  logic [PIN_W-1:0]  trc_pins;
  logic [7:0]        trc_seq, drops;
  logic [CW-1:0]     cnt;

  idli_tb_trace_m #(.DEPTH(DEPTH), .NUM_REGS(NUM_REGS), .PIN_W(PIN_W), .DATA_W(DATA_W)) dut (
    .i_tb_gck(clk), .i_tb_rst_n(rst_n), .i_tb_ctr(ctr), .i_tb_enc_new(enc_new), .i_tb_pc(pc),
    .i_tb_reg_wr(reg_wr), .i_tb_reg_idx(reg_idx), .i_tb_pred_wr(pred_wr), .i_tb_skip(skip),
    .i_tb_pin_wr(pin_wr), .i_tb_pin_idx(pin_idx), .i_tb_done(done), .i_tb_flush(flush),
    .o_tb_trc_vld(trc_vld), .i_tb_trc_rdy(rdy), .o_tb_trc_pc(trc_pc), .o_tb_trc_reg_sb(trc_reg),
    .o_tb_trc_pred_sb(trc_pred), .o_tb_trc_pins_sb(trc_pins), .o_tb_trc_seq(trc_seq),
    .o_tb_cnt(cnt), .o_tb_afull(afull), .o_tb_ovf(ovf), .o_tb_drops(drops));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: a queue of records plus an accumulator record.
  typedef struct {
    logic [DATA_W-1:0] pc; logic [NUM_REGS-1:0] regs; logic pred; logic [PIN_W-1:0] pins; logic [7:0] seq;
  } rec_t;
  rec_t q[$];
  rec_t acc;
  int   m_ovf, m_drops;
  logic [7:0] m_seq;

  function automatic void model_reset();
    q.delete();
    acc = '{default: '0};
    m_ovf = 0; m_drops = 0; m_seq = 0;
  endfunction

  // Apply the rules for one clock edge using the inputs currently driven.
  function automatic void model_edge();
    rec_t r;
    bit ret;
    ret = done && (ctr == 2'd3);
    r = acc; r.seq = m_seq;
    if (flush) begin
      q.delete(); m_ovf = 0; m_drops = 0;
    end else begin
      if (rdy && q.size() > 0) void'(q.pop_front());
      if (ret) begin
        if (q.size() < DEPTH) q.push_back(r);
        else begin m_ovf = 1; if (m_drops < 255) m_drops++; end
      end
    end
    if (ret) begin m_seq++; acc.regs = '0; acc.pred = 0; acc.pins = '0; end
    if (ctr == 2'd0) begin
      if (enc_new) acc.pc = pc;
      if (reg_wr && reg_idx != 0) acc.regs[reg_idx] = 1'b1;
      if (pred_wr) acc.pred = !skip;
      if (pin_wr) acc.pins[pin_idx] = 1'b1;
    end
  endfunction

  task automatic cmp_model();
    chk("vld", trc_vld, q.size() > 0);
    chk("cnt", cnt, q.size());
    chk("afull", afull, q.size() >= DEPTH-1);
    chk("ovf", ovf, m_ovf);
    chk("drops", drops, m_drops);
    if (q.size() > 0) begin
      chk("head_pc", trc_pc, q[0].pc);
      chk("head_reg", trc_reg, q[0].regs);
      chk("head_pred", trc_pred, q[0].pred);
      chk("head_pins", trc_pins, q[0].pins);
      chk("head_seq", trc_seq, q[0].seq);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk); #1;
    cmp_model();
  endtask

  task automatic do_reset();
    rst_n = 0; ctr = 0;
    {enc_new, reg_wr, pred_wr, pin_wr, done, flush, rdy, skip} = '0;
    model_reset();
    @(posedge clk); #1; @(posedge clk); #1;
    rst_n = 1;
  endtask

  // One 4-phase instruction window; side effects at phase 0, retire at 3.
  // rd3/fl3 drive ready/flush only on the phase-3 edge.
  task automatic instr(input logic [DATA_W-1:0] p, input bit en, input int ri, input bit pw,
                       input bit sk, input int pni, input bit dn, input bit rd3, input bit fl3);
    for (int ph = 0; ph < 4; ph++) begin
      ctr = 2'(ph);
      enc_new = (ph == 0) && en; pc = p;
      reg_wr = (ph == 0) && (ri >= 0); reg_idx = RIW'(ri);
      pred_wr = (ph == 0) && pw; skip = sk;
      pin_wr = (ph == 0) && (pni >= 0); pin_idx = PIW'(pni);
      done = (ph == 3) && dn; rdy = (ph == 3) && rd3; flush = (ph == 3) && fl3;
      tick();
    end
    {enc_new, reg_wr, pred_wr, pin_wr, done, rdy, flush} = '0; ctr = 0;
  endtask

  typedef struct {
    logic [DATA_W-1:0] pc; int ra, rb; bit pw, sk; int pn;
    logic [NUM_REGS-1:0] e_reg; bit e_pred; logic [PIN_W-1:0] e_pins;
  } vec_t;
  vec_t tbl[4];
  int rp;

  initial begin
    tbl[0] = '{16'h0040, 3, 5, 0, 0, -1, 16'h0028, 0, 4'h0};
    tbl[1] = '{16'h1234, 0, -1, 1, 1, 2, 16'h0000, 0, 4'h4};
    tbl[2] = '{16'hBEEF, 15, 0, 1, 0, 0, 16'h8000, 1, 4'h1};
    tbl[3] = '{16'h0001, 1, 1, 0, 0, 3, 16'h0002, 0, 4'h8};

    do_reset();
    chk("rst_vld", trc_vld, 0); chk("rst_cnt", cnt, 0); chk("rst_afull", afull, 0);
    chk("rst_ovf", ovf, 0); chk("rst_drops", drops, 0);

    // Table vectors: two accumulation windows, retire on the second.
    for (int i = 0; i < 4; i++) begin
      instr(tbl[i].pc, 1, tbl[i].ra, tbl[i].pw, tbl[i].sk, tbl[i].pn, 0, 0, 0);
      instr(16'h0, 0, tbl[i].rb, 0, 0, -1, 1, 0, 0);
      chk("tv_vld", trc_vld, 1); chk("tv_pc", trc_pc, tbl[i].pc);
      chk("tv_reg", trc_reg, tbl[i].e_reg); chk("tv_pred", trc_pred, tbl[i].e_pred);
      chk("tv_pins", trc_pins, tbl[i].e_pins); chk("tv_seq", trc_seq, i);
      rdy = 1; tick(); rdy = 0;
      chk("tv_pop", trc_vld, 0);
    end

    // Overflow: 10 retires into an 8-deep FIFO with no reader.
    do_reset();
    for (int i = 0; i < 10; i++) instr(DATA_W'(i), 1, -1, 0, 0, -1, 1, 0, 0);
    chk("ovf_cnt", cnt, 8); chk("ovf_afull", afull, 1); chk("ovf_ovf", ovf, 1);
    chk("ovf_drops", drops, 2); chk("ovf_head", trc_seq, 0);
    for (int i = 0; i < 8; i++) begin
      chk("drain_seq", trc_seq, i); chk("drain_pc", trc_pc, i);
      rdy = 1; tick(); rdy = 0;
    end
    chk("drain_empty", trc_vld, 0);

    // Full FIFO, retire with simultaneous pop.
    do_reset();
    for (int i = 0; i < 8; i++) instr(DATA_W'(i), 1, -1, 0, 0, -1, 1, 0, 0);
    instr(16'h0AAA, 1, -1, 0, 0, -1, 1, 1, 0);
    chk("pp_cnt", cnt, 8); chk("pp_ovf", ovf, 0); chk("pp_head", trc_seq, 1);
    for (int i = 1; i < 9; i++) begin
      chk("pp_seq", trc_seq, i);
      rdy = 1; tick(); rdy = 0;
    end

    // Flush coincident with retire (seq 9..17 pushed, 17 dropped).
    for (int i = 0; i < 9; i++) instr(DATA_W'(i), 1, -1, 0, 0, -1, 1, 0, 0);
    chk("fl_pre_ovf", ovf, 1);
    instr(16'h0077, 1, 7, 1, 0, 1, 1, 0, 1);
    chk("fl_cnt", cnt, 0); chk("fl_ovf", ovf, 0); chk("fl_drops", drops, 0);
    instr(16'h0078, 0, -1, 0, 0, -1, 1, 0, 0);
    chk("fl_seq", trc_seq, 19); chk("fl_reg", trc_reg, 0); chk("fl_pc", trc_pc, 16'h0077);
    rdy = 1; tick(); rdy = 0;

    // Reset mid-stream with 3 entries and seq 5.
    do_reset();
    for (int i = 0; i < 5; i++) instr(DATA_W'(i), 1, -1, 0, 0, -1, 1, 0, 0);
    rdy = 1; tick(); tick(); rdy = 0;
    chk("ms_cnt3", cnt, 3);
    ctr = 0; reg_wr = 1; reg_idx = 9; tick(); reg_wr = 0;
    #2 rst_n = 0; #1;
    chk("ms_rst_cnt", cnt, 0); chk("ms_rst_vld", trc_vld, 0);
    model_reset();
    @(posedge clk); #1; rst_n = 1;
    instr(16'h0, 0, -1, 0, 0, -1, 1, 0, 0);
    chk("ms_seq", trc_seq, 0); chk("ms_reg", trc_reg, 0);
    rdy = 1; tick(); rdy = 0;

    // Drop counter saturation.
    do_reset();
    for (int i = 0; i < 270; i++) instr(DATA_W'(i), 1, -1, 0, 0, -1, 1, 0, 0);
    chk("sat_drops", drops, 255); chk("sat_ovf", ovf, 1);

    // Random traffic, free-running phase, varied reader pressure.
    do_reset();
    for (int blk = 0; blk < 8; blk++) begin
      rp = (blk % 2) ? 90 : 15;
      for (int c = 0; c < 300; c++) begin
        ctr = ctr + 2'd1;
        enc_new = 1'($urandom_range(0, 1)); pc = DATA_W'($urandom);
        reg_wr = 1'($urandom_range(0, 1)); reg_idx = RIW'($urandom);
        pred_wr = 1'($urandom_range(0, 1)); skip = 1'($urandom_range(0, 1));
        pin_wr = 1'($urandom_range(0, 1)); pin_idx = PIW'($urandom);
        done = ($urandom_range(0, 99) < 60);
        rdy = ($urandom_range(0, 99) < rp);
        flush = ($urandom_range(0, 127) == 0);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
